// File: rtl/pwm_breathe_pkg.sv
// pwm_breathe_pkg: shared types and helpers for the breathing PWM generator.
// Used by pwm_breathe and pwm_breathe_ch (optional macro PWM_BREATHE_GAMMA_EN).
package pwm_breathe_pkg;

    typedef enum logic {UP, DOWN} dir_t;

    // Extra bits carried by ramp arithmetic so duty+STEP never wraps
    localparam int EXT_W = 1;

    function automatic int init_duty(input int i, input int ch, input int period);
        return (i * period) / ch;
    endfunction

endpackage

// File: rtl/pwm_breathe_ch.sv
// pwm_breathe_ch: one breathing channel - duty ramp FSM plus compare/output flop.
// PWM_BREATHE_GAMMA_EN adds a registered square-law compare value.
module pwm_breathe_ch
    import pwm_breathe_pkg::*;
#(
    parameter int CH     = 4,
    parameter int CW     = 12,
    parameter int PERIOD = 4095,
    parameter int STEP   = 16,
    parameter int IDX    = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] cnt_i,
    input  logic          upd_i,
    input  logic          en_i,
    output logic          out_o
);

    localparam int            AW   = CW + EXT_W;
    localparam int            II   = init_duty(IDX, CH, PERIOD);
    localparam logic [CW-1:0] INIT = CW'(II);
    localparam logic [AW-1:0] P_W  = AW'(PERIOD);
    localparam logic [AW-1:0] S_W  = AW'(STEP);

    logic [CW-1:0] duty_q, duty_d, cmp;
    logic [AW-1:0] ext, sum, dif;
    logic          out_q, out_d, top, bot;
    dir_t          dir_q, dir_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            duty_q <= INIT;
            dir_q  <= UP;
            out_q  <= 1'b0;
        end else begin
            duty_q <= duty_d;
            dir_q  <= dir_d;
            out_q  <= out_d;
        end
    end

    always_comb begin
        ext    = {{EXT_W{1'b0}}, duty_q};
        sum    = ext + S_W;
        dif    = ext - S_W;
        top    = sum >= P_W;
        bot    = ext <= S_W;
        duty_d = duty_q;
        dir_d  = dir_q;
        if (upd_i && dir_q == UP) begin
            duty_d = top ? CW'(PERIOD) : sum[CW-1:0];
            dir_d  = top ? DOWN : UP;
        end else if (upd_i) begin
            duty_d = bot ? '0 : dif[CW-1:0];
            dir_d  = bot ? UP : DOWN;
        end
    end

`ifdef PWM_BREATHE_GAMMA_EN
    localparam logic [CW-1:0] INIT_CMP = CW'((II * II) >> CW);

    logic [2*CW-1:0] sq;
    logic [CW-1:0]   cmp_q;

    // Loaded at the period wrap with the post-update duty so it lands at cnt==0
    always_comb sq = {{CW{1'b0}}, duty_d} * {{CW{1'b0}}, duty_d};

    always_ff @(posedge clk) begin
        if (rst)
            cmp_q <= INIT_CMP;
        else if (cnt_i == CW'(PERIOD - 1))
            cmp_q <= CW'(sq >> CW);
    end

    assign cmp = cmp_q;
`else
    assign cmp = duty_q;
`endif

    always_comb out_d = en_i & (cnt_i < cmp);

    assign out_o = out_q;

endmodule

// File: rtl/pwm_breathe.sv
// pwm_breathe: multi-channel LED breathing PWM with shared period counter.
// Optional square-law correction under PWM_BREATHE_GAMMA_EN.
module pwm_breathe
    import pwm_breathe_pkg::*;
#(
    parameter int CH     = 4,
    parameter int CW     = 12,
    parameter int PERIOD = 4095,
    parameter int STEP   = 16,
    parameter int HOLD   = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [CH-1:0] out,
    output logic          period_start
);

    localparam int HW = HOLD > 1 ? $clog2(HOLD) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          ps_q, wrap, last, upd;

    always_comb begin
        wrap   = cnt_q == CW'(PERIOD - 1);
        last   = hold_q == HW'(HOLD - 1);
        upd    = wrap & en & last;
        cnt_d  = wrap ? '0 : cnt_q + CW'(1);
        hold_d = (wrap & en) ? (last ? '0 : hold_q + HW'(1)) : hold_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            hold_q <= '0;
            ps_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            hold_q <= hold_d;
            ps_q   <= cnt_q == '0;
        end
    end

    assign period_start = ps_q;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        pwm_breathe_ch #(
            .CH(CH), .CW(CW), .PERIOD(PERIOD), .STEP(STEP), .IDX(i)
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .cnt_i(cnt_q),
            .upd_i(upd),
            .en_i (en),
            .out_o(out[i])
        );
    end

endmodule
